// File: rtl/rom_fetch_if.sv
// Fetch-unit bus: boot ROM read port, redirect input and the decode-side valid/ready output.
// The master modport is the fetch unit; the slave modport is the ROM/decode side.
interface rom_fetch_if #(
  parameter int ROM_W = 11
);
  logic [ROM_W-1:0] rom_adr;
  logic [31:0]      rom_dat;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [31:0]      out_instr;
  logic             out_fault;

  modport master (
    output rom_adr, out_valid, out_pc, out_instr, out_fault,
    input  rom_dat, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  rom_adr, out_valid, out_pc, out_instr, out_fault,
    output rom_dat, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/rom_fetch.sv
// Instruction fetch front end: PC, one-cycle ROM read in flight, 2-entry output buffer,
// redirect flush and halt-on-fault.
module rom_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ROM_SIZE = 8192
) (
  input  logic      clk,
  input  logic      rst,
  rom_fetch_if.master bus
);
  localparam int RomWidth = $clog2(ROM_SIZE / 4);

  logic [31:0] r_pc_p0;
  logic        r_vld_p1;
  logic [31:0] r_pc_p1;
  logic        r_fault_p1;
  logic [31:0] r_fifo_pc    [2];
  logic [31:0] r_fifo_instr [2];
  logic [1:0]  r_fifo_fault;
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic        r_halted;

  logic        w_pop;
  logic        w_push;
  logic        w_issue;
  logic        w_pc_fault;
  logic [2:0]  w_occ;

  function automatic logic pc_fault(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc[31:RomWidth+2] != '0);
  endfunction

  assign bus.rom_adr   = r_pc_p0[RomWidth+1:2];
  assign bus.out_valid = (r_count != 2'd0);
  assign bus.out_pc    = r_fifo_pc[r_rd_ptr];
  assign bus.out_instr = r_fifo_instr[r_rd_ptr];
  assign bus.out_fault = r_fifo_fault[r_rd_ptr];

  assign w_pop      = bus.out_valid && bus.out_ready;
  assign w_push     = r_vld_p1;
  assign w_pc_fault = pc_fault(r_pc_p0);
  // Occupancy after this cycle's pop, counting the read already in flight.
  assign w_occ      = {1'b0, r_count} + {2'b00, r_vld_p1} - {2'b00, w_pop};
  assign w_issue    = !rst && !bus.redirect_valid && !r_halted && (w_occ < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_p0         <= RESET_PC;
      r_vld_p1        <= 1'b0;
      r_pc_p1         <= '0;
      r_fault_p1      <= 1'b0;
      r_fifo_pc[0]    <= '0;
      r_fifo_pc[1]    <= '0;
      r_fifo_instr[0] <= '0;
      r_fifo_instr[1] <= '0;
      r_fifo_fault    <= '0;
      r_wr_ptr        <= 1'b0;
      r_rd_ptr        <= 1'b0;
      r_count         <= '0;
      r_halted        <= 1'b0;
    end else if (bus.redirect_valid) begin
      // The response landing this cycle belongs to the old stream and is dropped.
      r_pc_p0  <= bus.redirect_pc;
      r_vld_p1 <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
      r_halted <= 1'b0;
    end else begin
      // p0 -> p1: address presented to the ROM this cycle
      r_vld_p1 <= w_issue;
      if (w_issue) begin
        r_pc_p1    <= r_pc_p0;
        r_fault_p1 <= w_pc_fault;
        r_pc_p0    <= r_pc_p0 + 32'd4;
        if (w_pc_fault) r_halted <= 1'b1;
      end
      // p1 -> buffer: ROM data captured alongside its PC
      if (w_push) begin
        r_fifo_pc[r_wr_ptr]    <= r_pc_p1;
        r_fifo_instr[r_wr_ptr] <= r_fault_p1 ? 32'h0 : bus.rom_dat;
        r_fifo_fault[r_wr_ptr] <= r_fault_p1;
        r_wr_ptr               <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end
endmodule

// File: doc/rom_fetch.md
# rom_fetch

Instruction fetch front end that reads from the synchronous boot ROM (one-cycle registered read, word-addressed) and presents one instruction per cycle to the decode stage over a valid/ready handshake. Holds the program counter, hides the ROM's read latency behind a 2-entry buffer so backpressure never loses or duplicates a word, and supports a pipeline redirect (branch/trap target). Out-of-range or misaligned PCs produce a fault-tagged entry instead of a ROM read result.

## Interface
- RESET_PC, 32'h0000_0000: PC fetched first after reset.
- ROM_SIZE, 8192: ROM size in bytes; must match the ROM instance and be a power of two ≥ 8.
- RomWidth (localparam), $clog2(ROM_SIZE/4): ROM word-address width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- rom_adr  out  RomWidth  ROM word address; always equals pc[RomWidth+1:2].
- rom_dat  in  32  ROM read data; valid the cycle after the address was presented.
- redirect_valid  in  1  load new PC; flush buffered and in-flight fetches.
- redirect_pc  in  32  redirect target byte address.
- out_valid  out  1  head entry available.
- out_ready  in  1  decode accepts head entry.
- out_pc  out  32  byte PC of head entry.
- out_instr  out  32  instruction word of head entry.
- out_fault  out  1  head entry is a fetch fault; out_instr is 0.

## Operation
- State: pc (32b), inflight (1b: an issue occurred last cycle), inflight_pc/inflight_fault, FIFO of depth 2 {pc, instr, fault}, count (0..2), halted (1b).
- pop = out_valid && out_ready. out_valid = (count != 0). Head fields come from FIFO storage (registered, no comb path from rom_dat or redirect).
- issue = !rst && !redirect_valid && !halted && (count + inflight - pop < 2).
- On issue: inflight <= 1, inflight_pc <= pc, inflight_fault <= fault(pc), pc <= pc + 4 (32-bit wrap). If fault(pc): halted <= 1.
- fault(pc) = (pc[1:0] != 0) || (pc[31:RomWidth+2] != 0).
- Response: when inflight is 1, push {inflight_pc, fault ? 32'h0 : rom_dat, inflight_fault} into FIFO at end of cycle. Push and pop in same cycle allowed; count updates by push - pop.
- Redirect (cycle R): a pop in R completes normally; at end of R, FIFO cleared (count <= 0), inflight <= 0 (the response arriving in R is discarded), halted <= 0, pc <= redirect_pc. No issue in R.
- Halted: after a fault entry is issued, no further issue until redirect or reset; already-buffered entries still drain.
- Reset (any cycle, including mid-stream): pc <= RESET_PC, count <= 0, inflight <= 0, halted <= 0, FIFO storage <= 0. rst overrides redirect_valid.

## Timing
- Reset values: out_valid 0, out_pc 0, out_instr 0, out_fault 0, rom_adr = RESET_PC[RomWidth+1:2].
- Cycle 0 = first cycle with rst low: issue RESET_PC; rom_dat valid in cycle 1; out_valid first high in cycle 2. Issue-to-out_valid latency 2.
- Steady state with out_ready held high: one entry per cycle, consecutive PCs, no bubbles.
- Redirect in cycle R: out_valid low in R+1 and R+2 (unless reset), redirect_pc issued in R+1, its entry valid in R+3.
- count never exceeds 2; with out_ready low, issue stops once count + inflight = 2.

## Test plan
- Reset, RESET_PC=0, ROM words 0..3 = 0x11111111..0x44444444, out_ready=1 -> out_valid rises cycle 2; entries (0x0,0x11111111),(0x4,0x22222222),(0x8,0x33333333),(0xC,0x44444444) on consecutive cycles, out_fault 0.
- Drop out_ready for 5 cycles mid-stream -> count saturates at 2, rom_adr frozen, on release PCs continue consecutively with no drop or duplicate.
- With FIFO full and out_ready=0, redirect to 0x100 -> out_valid low R+1,R+2; cycle R+3 out_pc 0x100, out_instr = ROM word 0x40.
- Redirect to 0x102 -> single entry pc 0x102, instr 0, fault 1; no further out_valid for 10 cycles; redirect to 0x0 resumes normally.
- Redirect to 0x1FF8, ROM_SIZE=8192 -> entries 0x1FF8, 0x1FFC normal, then 0x2000 with fault 1, then halted.
- Assert rst one cycle with FIFO full and a pop pending -> out_valid 0 next cycle; restart from RESET_PC with out_valid 2 cycles after rst falls.
